// File: rtl/cell_vector_io.sv
// cell_vector_io: byte-serial stimulus/response adapter for a WIDTH-bit combinational cell.
// Optional macro CELL_VECIO_CHECKSUM_EN appends an XOR checksum byte to every response.
module cell_vector_io #(
  parameter int WIDTH  = 96,
  parameter int SETTLE = 2
) (
  input  logic             clkin_data,
  input  logic             rstn_data,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] out_data,
  output logic [7:0]       m_byte,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [15:0]      vec_count
);
  localparam int NBYTES = WIDTH / 8;
`ifdef CELL_VECIO_CHECKSUM_EN
  localparam int NOUT = NBYTES + 1;
`else
  localparam int NOUT = NBYTES;
`endif
  localparam int IDXW = $clog2(NOUT + 1);
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDXW-1:0] LAST_IN  = IDXW'(NBYTES - 1);
  localparam logic [IDXW-1:0] LAST_OUT = IDXW'(NOUT - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_in_data;
  logic [WIDTH-1:0] r_resp;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [15:0]      r_vec_count;
  logic [7:0]       w_resp_byte;
  logic             w_s_acc;
  logic             w_m_acc;

  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) r_state <= ST_LOAD;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_acc     = 1'b0;
    w_m_acc     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_s_acc = s_valid;
        if (s_valid && (r_idx == LAST_IN)) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_m_acc = m_ready;
        if (m_ready && (r_idx == LAST_OUT)) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Merge the incoming byte so the final accept can publish the whole vector at once.
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int k = 0; k < NBYTES; k++)
      if (r_idx == IDXW'(k)) w_shadow_nxt[8*k +: 8] = s_byte;
  end

`ifdef CELL_VECIO_CHECKSUM_EN
  logic [7:0] w_csum;
  always_comb begin
    w_csum = 8'h00;
    for (int k = 0; k < NBYTES; k++) w_csum = w_csum ^ r_resp[8*k +: 8];
  end
`endif

  always_comb begin
    w_resp_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++)
      if (r_idx == IDXW'(k)) w_resp_byte = r_resp[8*k +: 8];
`ifdef CELL_VECIO_CHECKSUM_EN
    if (r_idx == IDXW'(NBYTES)) w_resp_byte = w_csum;
`endif
  end

  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_in_data   <= '0;
      r_resp      <= '0;
      r_vec_count <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_s_acc) begin
            r_shadow <= w_shadow_nxt;
            r_idx    <= r_idx + 1'b1;
            if (r_idx == LAST_IN) begin
              r_in_data <= w_shadow_nxt;
              r_cnt     <= CNTW'(SETTLE - 1);
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_resp <= out_data;
            r_idx  <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_m_acc) begin
            if (r_idx == LAST_OUT) begin
              r_idx       <= '0;
              r_vec_count <= r_vec_count + 16'd1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (r_state == ST_LOAD);
  assign m_valid   = (r_state == ST_DRAIN);
  assign m_byte    = m_valid ? w_resp_byte : 8'h00;
  assign in_data   = r_in_data;
  assign busy      = (r_state != ST_LOAD) || (r_idx != '0);
  assign vec_count = r_vec_count;
endmodule

// File: doc/cell_vector_io.md
# cell_vector_io

Byte-serial stimulus/response adapter for the 96-bit combinational cell under test. It sits on the opposite side of the cell's `in_data`/`out_data` ports. It assembles a 96-bit stimulus vector from an inbound byte stream and drives it onto the cell's `in_data`. After a fixed settle time it captures the cell's `out_data` and streams that response back out as bytes. One vector is in flight at a time; the block counts completed vectors.

## Interface
Parameters:
- `WIDTH`, 96, vector width in bits; must be a multiple of 8 (NBYTES = WIDTH/8).
- `SETTLE`, 2, cycles between applying a stimulus and capturing the response; must be ≥1.

Ports:
- `clkin_data`  in  1  sole clock, rising edge.
- `rstn_data`  in  1  reset, asynchronous assert, active-low.
- `s_byte`  in  8  stimulus byte.
- `s_valid`  in  1  stimulus byte valid.
- `s_ready`  out  1  stimulus byte accepted when `s_valid && s_ready`.
- `in_data`  out  WIDTH  stimulus vector driven to the cell.
- `out_data`  in  WIDTH  response vector from the cell.
- `m_byte`  out  8  response byte.
- `m_valid`  out  1  response byte valid.
- `m_ready`  in  1  response byte consumed when `m_valid && m_ready`.
- `busy`  out  1  vector in progress.
- `vec_count`  out  16  completed vectors, wraps modulo 2^16.

## Operation
- Three states: LOAD, SETTLE, DRAIN. Reset enters LOAD with the byte index at 0.
- **LOAD**
  - `s_ready`=1 and `m_valid`=0.
  - Each accepted byte k (0..NBYTES-1) is written into a shadow register at bits [8k+7:8k]. Byte order is little-endian.
  - On acceptance of byte NBYTES-1, the full shadow (including that byte) is copied into `in_data`, the settle counter loads SETTLE-1, and the state moves to SETTLE.
  - `in_data` never shows a partially loaded vector.
- **SETTLE**
  - `s_ready`=0 and `m_valid`=0.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: the response register captures `out_data`, the byte index clears, and the state moves to DRAIN.
- **DRAIN**
  - `m_valid`=1. `m_byte` = response byte at the current index.
  - `m_byte` is held stable while `m_ready`=0.
  - On each handshake the index increments.
  - On the handshake of the last byte: `vec_count` increments, the index clears, and the state moves to LOAD.
  - `in_data` holds its value until the next vector completes loading.
- `busy` = (state≠LOAD) or (index≠0).
- `s_valid` outside LOAD is ignored. No byte is consumed or lost.
- Reset while in any state:
  - all state clears immediately;
  - a partially loaded or partially drained vector is discarded;
  - `vec_count` returns to 0.
- Reset values: `s_ready`=1, `m_valid`=0, `m_byte`=0x00, `in_data`=0, `busy`=0, `vec_count`=0.

## Timing
- All outputs are registered or decoded from registered state only. There are no combinational paths from `s_valid` or `m_ready` to outputs.
- The last stimulus byte is accepted at edge T.
  - New `in_data` is visible from T.
  - `out_data` is sampled at edge T+SETTLE.
  - `m_valid` rises after T+SETTLE with byte 0.
- The cell output therefore has exactly SETTLE full cycles to settle.
- After the last response handshake at edge D, `s_ready`=1 from D, and a new byte may be accepted at D+1.
- Minimum vector period with no backpressure: NBYTES + SETTLE + NBYTES(+1) cycles.

## Configuration
- Macro: `CELL_VECIO_CHECKSUM_EN`.
- **Defined:** DRAIN emits NBYTES+1 bytes. The final byte is the XOR of all NBYTES response bytes. `vec_count` increments only on that final byte's handshake.
- **Undefined:** DRAIN emits exactly NBYTES bytes. No checksum logic is present.

## Test plan
- **Loopback, defaults, macro off.** Tie `out_data`=`in_data`. Send bytes 0x01..0x0C with continuous valid.
  - `in_data`=0x0C0B0A090807060504030201 one cycle after the 12th accept.
  - `m_byte` sequence is 0x01..0x0C. `vec_count`=1.
- **Loopback, macro on.** Same stimulus as above.
  - A 13th byte of 0x0C is emitted.
  - `vec_count` becomes 1 only after the 13th handshake.
- **Settle timing.** SETTLE=3. The cell model changes `out_data` from 0xAA.. to 0x55.. exactly 2 cycles after `in_data` updates.
  - All response bytes read 0x55.
  - `m_valid` first rises 3 cycles after the last accept.
- **Backpressure.** Hold `m_ready`=0 for 5 cycles while byte index 3 is presented.
  - `m_byte` stays stable for all 5 cycles.
  - No bytes are skipped or duplicated.
  - `s_valid` pulses during DRAIN are not accepted (`s_ready`=0).
- **Reset mid-operation.** Assert `rstn_data` low asynchronously (mid-cycle) after 5 stimulus bytes, and separately during DRAIN index 7.
  - All outputs reach reset values immediately.
  - A following full 12-byte vector is handled correctly from byte 0.
- **Back-to-back vectors.** Stream 3 vectors (0x00.., 0xFF.., 0xA5..) with `m_ready`=1.
  - Responses arrive in order.
  - `vec_count`=3.
  - The first byte of the next vector is accepted the cycle after the last response handshake.
